id_ex_hazard_stage: RTL

- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Sits between decode and execute. Its registered ID_EX_RegisterRs/Rt feed the forwarding unit; ID_EX_MemRead feeds back into its own stall detection.
- Inserts one bubble per load-use hazard, squashes on branch flush, and freezes on external hold.
- Keeps a saturating count of bubbles inserted, for performance measurement.

---
 rtl/mips_pipe_pkg.sv | 45 ++++
 rtl/id_ex_hazard_stage_hazard_detect.sv | 40 ++++
 rtl/id_ex_hazard_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pipe_pkg
//  Description : Shared types and constants for the 5-stage MIPS pipeline:
//                ALUOp classes, datapath widths, the packed control bundle
//                and the all-zero NOP control word.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pipe_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // ALU operation classes handed from decode to the ALU control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       ALUSrc;
    logic       RegDst;
    logic [1:0] ALUOp;
  } ctrl_t;

  // A bubble carries no side effects: no writes, no memory access
  localparam ctrl_t NOP_CTRL = '0;

  // Load in EX whose destination is a source of the instruction in ID.
  // $zero as the load destination is never a real dependency.
  function automatic logic loadUseHit(
    input logic             exMemRead,
    input logic [REG_W-1:0] exRt,
    input logic [REG_W-1:0] idRs,
    input logic [REG_W-1:0] idRt
  );
    return exMemRead && (exRt != '0) && ((exRt == idRs) || (exRt == idRt));
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use stall detection and the matching
//                PC / IF-ID write enables.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_hold,
  input  logic             i_idExMemRead,
  input  logic [REG_W-1:0] i_idExRegisterRt,
  input  logic [REG_W-1:0] i_ifIdRegisterRs,
  input  logic [REG_W-1:0] i_ifIdRegisterRt,
  output logic             o_stall,
  output logic             o_pcWrite,
  output logic             o_ifIdWrite
);
  import mips_pipe_pkg::*;

  logic w_rawHazard;
  logic w_frontFreeze;

  assign w_rawHazard = loadUseHit(i_idExMemRead, i_idExRegisterRt,
                                  i_ifIdRegisterRs, i_ifIdRegisterRt);

  // A taken branch discards the dependent instruction, a hold freezes
  // everything anyway, and reset state is a NOP: none of them may stall.
  assign o_stall = w_rawHazard && !i_flush && !i_hold && !i_reset;

  // The front end is frozen both for the bubble and for a global hold
  assign w_frontFreeze = o_stall || i_hold;
  assign o_pcWrite     = !w_frontFreeze;
  assign o_ifIdWrite   = !w_frontFreeze;

endmodule
`default_nettype wire

// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_hazard_stage
//  Description : ID/EX pipeline register with integrated load-use hazard
//                detection. Inserts one bubble per load-use hazard, squashes
//                on flush, freezes on hold and counts inserted bubbles with
//                a saturating counter. The RUN/BUBBLE behaviour follows from
//                the registered MemRead bit alone; there is no state register.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  IF_ID_RegisterRs,
  input  logic [REG_W-1:0]  IF_ID_RegisterRt,
  input  logic [REG_W-1:0]  IF_ID_RegisterRd,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegDst,
  input  logic [1:0]        ID_ALUOp,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              Flush,
  input  logic              Hold,
  output logic [REG_W-1:0]  ID_EX_RegisterRs,
  output logic [REG_W-1:0]  ID_EX_RegisterRt,
  output logic [REG_W-1:0]  ID_EX_RegisterRd,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemToReg,
  output logic              ID_EX_ALUSrc,
  output logic              ID_EX_RegDst,
  output logic [1:0]        ID_EX_ALUOp,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic              Stall,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic [CNT_W-1:0]  StallCount
);
  import mips_pipe_pkg::*;

  ctrl_t             w_idCtrl;
  ctrl_t             r_ctrl;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_readData1;
  logic [DATA_W-1:0] r_readData2;
  logic [DATA_W-1:0] r_imm;
  logic [CNT_W-1:0]  r_stallCount;
  logic              w_stall;
  logic              w_pcWrite;
  logic              w_ifIdWrite;
  logic              w_countSat;

  assign w_idCtrl = '{RegWrite: ID_RegWrite, MemRead: ID_MemRead,
                      MemWrite: ID_MemWrite, MemToReg: ID_MemToReg,
                      ALUSrc: ID_ALUSrc, RegDst: ID_RegDst, ALUOp: ID_ALUOp};

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .i_reset          (reset),
    .i_flush          (Flush),
    .i_hold           (Hold),
    .i_idExMemRead    (r_ctrl.MemRead),
    .i_idExRegisterRt (r_rt),
    .i_ifIdRegisterRs (IF_ID_RegisterRs),
    .i_ifIdRegisterRt (IF_ID_RegisterRt),
    .o_stall          (w_stall),
    .o_pcWrite        (w_pcWrite),
    .o_ifIdWrite      (w_ifIdWrite)
  );

  assign w_countSat = &r_stallCount;

  // Pipeline register: reset > flush > hold > bubble > capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl       <= NOP_CTRL;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_readData1  <= '0;
      r_readData2  <= '0;
      r_imm        <= '0;
      r_stallCount <= '0;
    end else if (Flush || w_stall) begin
      // Both load a bubble; only a load-use bubble is counted
      r_ctrl      <= NOP_CTRL;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_readData1 <= '0;
      r_readData2 <= '0;
      r_imm       <= '0;
      if (w_stall && !w_countSat) begin
        r_stallCount <= r_stallCount + CNT_W'(1);
      end
    end else if (!Hold) begin
      r_ctrl      <= w_idCtrl;
      r_rs        <= IF_ID_RegisterRs;
      r_rt        <= IF_ID_RegisterRt;
      r_rd        <= IF_ID_RegisterRd;
      r_readData1 <= ID_ReadData1;
      r_readData2 <= ID_ReadData2;
      r_imm       <= ID_Imm;
    end
  end

  assign ID_EX_RegisterRs = r_rs;
  assign ID_EX_RegisterRt = r_rt;
  assign ID_EX_RegisterRd = r_rd;
  assign ID_EX_RegWrite   = r_ctrl.RegWrite;
  assign ID_EX_MemRead    = r_ctrl.MemRead;
  assign ID_EX_MemWrite   = r_ctrl.MemWrite;
  assign ID_EX_MemToReg   = r_ctrl.MemToReg;
  assign ID_EX_ALUSrc     = r_ctrl.ALUSrc;
  assign ID_EX_RegDst     = r_ctrl.RegDst;
  assign ID_EX_ALUOp      = r_ctrl.ALUOp;
  assign ID_EX_ReadData1  = r_readData1;
  assign ID_EX_ReadData2  = r_readData2;
  assign ID_EX_Imm        = r_imm;
  assign Stall            = w_stall;
  assign PCWrite          = w_pcWrite;
  assign IF_ID_Write      = w_ifIdWrite;
  assign StallCount       = r_stallCount;

endmodule
`default_nettype wire
